// File: rtl/mod_21_v_1.sv
// Residue-preserving modulo-21 digit summer: adds the six 6-bit digits of n (64 == 1 mod 21).
// Define MOD21_FINAL_REDUCE_EN to add a second stage that reduces the sum to exactly n mod 21.
module mod_21_v_1 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] n,
    output logic        out_valid,
    output logic [8:0]  bit_sum
);

    logic [8:0] digitSum_d;
    logic [8:0] digitSum_q;
    logic       valid1_q;

    // Each digit is at most 63, so six of them top out at 378 and fit in 9 bits.
    always_comb begin
        digitSum_d = {3'b000, n[5:0]}
                   + {3'b000, n[11:6]}
                   + {3'b000, n[17:12]}
                   + {3'b000, n[23:18]}
                   + {3'b000, n[29:24]}
                   + {7'b0000000, n[31:30]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digitSum_q <= 9'd0;
            valid1_q   <= 1'b0;
        end else begin
            valid1_q <= in_valid;
            if (in_valid) begin
                digitSum_q <= digitSum_d;
            end
        end
    end

`ifdef MOD21_FINAL_REDUCE_EN
    logic [6:0] fold_d;
    logic [6:0] reduced_d;
    logic [8:0] reducedSum_q;
    logic       valid2_q;

    // Folding bits [8:6] back in keeps the residue and bounds the value at 68,
    // so three conditional subtractions are always enough.
    always_comb begin
        fold_d    = {1'b0, digitSum_q[5:0]} + {4'b0000, digitSum_q[8:6]};
        reduced_d = fold_d;
        if (reduced_d >= 7'd21) reduced_d = reduced_d - 7'd21;
        if (reduced_d >= 7'd21) reduced_d = reduced_d - 7'd21;
        if (reduced_d >= 7'd21) reduced_d = reduced_d - 7'd21;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reducedSum_q <= 9'd0;
            valid2_q     <= 1'b0;
        end else begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
                reducedSum_q <= {2'b00, reduced_d};
            end
        end
    end

    assign bit_sum   = reducedSum_q;
    assign out_valid = valid2_q;
`else
    assign bit_sum   = digitSum_q;
    assign out_valid = valid1_q;
`endif

endmodule

// File: tb/tb_mod_21_v_1.sv
// Self-checking bench for mod_21_v_1; follows MOD21_FINAL_REDUCE_EN like the design does.
module tb_mod_21_v_1;

`ifdef MOD21_FINAL_REDUCE_EN
    localparam int LAT      = 2;
    localparam int MAX_SUM  = 20;
    localparam int EXP_ALL1 = 3;
    localparam int EXP_LOW3 = 0;
    localparam int EXP_21   = 0;
`else
    localparam int LAT      = 1;
    localparam int MAX_SUM  = 378;
    localparam int EXP_ALL1 = 318;
    localparam int EXP_LOW3 = 252;
    localparam int EXP_21   = 21;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] n;
    logic        out_valid;
    logic [8:0]  bit_sum;

    int assertCount = 0;
    int failCount   = 0;

    logic [32:0] pipeQ[$];
    int          expValid;
    int          expSum;
    longint      heldN;
    int          obsQ[$];

    mod_21_v_1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .n         (n),
        .out_valid (out_valid),
        .bit_sum   (bit_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the arithmetic definition, not from the adder tree.
    function automatic int refSum(input longint x);
        int s;
`ifdef MOD21_FINAL_REDUCE_EN
        s = int'(x % 21);
`else
        longint r;
        s = 0;
        r = x;
        for (int i = 0; i < 6; i++) begin
            s += int'(r % 64);
            r  = r / 64;
        end
`endif
        return s;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        pipeQ.delete();
        for (int i = 0; i < LAT - 1; i++) pipeQ.push_back(33'd0);
        expValid = 0;
        expSum   = 0;
        heldN    = 0;
    endtask

    task automatic modelStep(input logic v, input logic [31:0] x);
        logic [32:0] head;
        pipeQ.push_back({v, x});
        head     = pipeQ.pop_front();
        expValid = int'(head[32]);
        if (head[32]) begin
            heldN  = longint'(head[31:0]);
            expSum = refSum(heldN);
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, check at the next fall.
    task automatic applyStimulus(input logic v, input logic [31:0] x);
        in_valid = v;
        n        = x;
        @(posedge clk);
        modelStep(v, x);
        @(negedge clk);
        checkOutput("out_valid", int'(out_valid), expValid);
        checkOutput("bit_sum", int'(bit_sum), expSum);
        if (out_valid) obsQ.push_back(int'(bit_sum));
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input int expConst);
        applyStimulus(1'b1, x);
        for (int i = 0; i < LAT - 1; i++) applyStimulus(1'b0, 32'd0);
        checkOutput({tag, "_valid"}, int'(out_valid), 1);
        checkOutput(tag, int'(bit_sum), expConst);
    endtask

    initial begin
        logic [31:0] x;
        logic        v;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        n        = 32'd0;
        modelReset();
        #2;
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_sum", int'(bit_sum), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        directed("zero", 32'h0000_0000, 0);
        directed("all_ones", 32'hFFFF_FFFF, EXP_ALL1);
        directed("low24", 32'h00FF_FFFF, EXP_LOW3);
        directed("hold_after_idle", 32'h0000_0040, 1);
        applyStimulus(1'b0, 32'hDEAD_BEEF);
        checkOutput("idle_holds_sum", int'(bit_sum), 1);
        checkOutput("idle_drops_valid", int'(out_valid), 0);

        // Back-to-back operands must stream out on consecutive cycles.
        obsQ.delete();
        applyStimulus(1'b1, 32'd21);
        applyStimulus(1'b1, 32'd64);
        applyStimulus(1'b1, 32'd20);
        for (int i = 0; i < LAT; i++) applyStimulus(1'b0, 32'd0);
        checkOutput("b2b_count", obsQ.size(), 3);
        if (obsQ.size() == 3) begin
            checkOutput("b2b_first", obsQ[0], EXP_21);
            checkOutput("b2b_second", obsQ[1], 1);
            checkOutput("b2b_third", obsQ[2], 20);
        end

        // Asynchronous reset while a result is showing, with more work still in flight.
        applyStimulus(1'b1, 32'h0000_0FFF);
        applyStimulus(1'b1, 32'h1234_5678);
        for (int i = 0; i < LAT - 1; i++) applyStimulus(1'b1, 32'h0000_0013);
        checkOutput("pre_reset_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        n        = 32'hFFFF_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", int'(out_valid), 0);
        checkOutput("async_reset_sum", int'(bit_sum), 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("held_reset_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        modelReset();
        for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b0, 32'hFFFF_FFFF);
        directed("post_reset", 32'd41, 41 % 21 == 20 ? refSum(41) : refSum(41));

        // Randomized sweep over the low 24-bit range plus full 32-bit values.
        for (int i = 0; i < 3000; i++) begin
            if (i < 400)       x = 32'(i);
            else if (i < 2000) x = $urandom_range(32'h00FF_FFFF, 0);
            else               x = $urandom;
            v = ($urandom_range(3, 0) != 0);
            applyStimulus(v, x);
            if (out_valid) begin
                checkOutput("sweep_mod21", int'(bit_sum) % 21, int'(heldN % 21));
                checkOutput("sweep_range", int'(int'(bit_sum) <= MAX_SUM), 1);
            end
        end
        for (int i = 0; i < LAT; i++) applyStimulus(1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
